// File: rtl/vid_seq_pkg.sv
// Shared definitions for the video line sequencer: FSM state encoding,
// state width and the saturation limit used by the optional status counters
// (enabled with VID_SEQ_STATUS_COUNTERS_EN).
package vid_seq_pkg;

    localparam int STATE_W = 3;
    localparam logic [15:0] SAT_LIMIT = 16'hFFFF;

    typedef enum logic [STATE_W-1:0] {
        IDLE       = 3'd0,
        SYNC       = 3'd1,
        WAIT_FRAME = 3'd2,
        ACTIVE     = 3'd3,
        RESYNC     = 3'd4
    } seq_state_e;

    // Increment that holds at the saturation limit.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == SAT_LIMIT) ? value : (value + 16'd1);
    endfunction

endpackage

// File: rtl/vid_plane_phase_counter.sv
// Colour-plane phase tracker. In serial mode it counts accepted beats
// 0..N-1 and flags the beat that completes a sample; otherwise every beat
// is a complete sample.
module vid_plane_phase_counter
    import vid_seq_pkg::*;
#(
    parameter int NUMBER_OF_COLOUR_PLANES       = 3,
    parameter int COLOUR_PLANES_ARE_IN_PARALLEL = 0,
    parameter int LOG2_NUMBER_OF_COLOUR_PLANES  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_advance,
    input  logic i_hd_sdn,
    output logic o_start_of_sample,
    output logic o_sample_strobe
);

    localparam int PW = LOG2_NUMBER_OF_COLOUR_PLANES;
    localparam logic [PW-1:0] LAST_PHASE = PW'(NUMBER_OF_COLOUR_PLANES - 1);
    localparam logic [PW-1:0] ONE_P = PW'(1);
    localparam bit SERIAL_CAPABLE = (NUMBER_OF_COLOUR_PLANES > 1) &&
                                    (COLOUR_PLANES_ARE_IN_PARALLEL == 0);

    logic          w_serial;
    logic [PW-1:0] r_phase;

    assign w_serial          = SERIAL_CAPABLE && !i_hd_sdn;
    assign o_start_of_sample = w_serial ? (r_phase == '0) : 1'b1;
    assign o_sample_strobe   = i_advance & (w_serial ? (r_phase == LAST_PHASE) : 1'b1);

    // Phase register: held at 0 when cleared or when each beat is a full sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= '0;
        end else if (i_clr || !w_serial) begin
            r_phase <= '0;
        end else if (i_advance) begin
            r_phase <= (r_phase == LAST_PHASE) ? '0 : (r_phase + ONE_P);
        end
    end

endmodule

// File: rtl/vid_line_sequencer.sv
// Paces an Avalon-ST pixel stream into the clocked-video output: locks to
// frame starts, accepts beats on active-picture cycles, tracks x/y/plane
// position and flags underflow and sop/eop misalignment.
// Optional error counters are built when VID_SEQ_STATUS_COUNTERS_EN is defined.
module vid_line_sequencer
    import vid_seq_pkg::*;
#(
    parameter int NUMBER_OF_COLOUR_PLANES       = 3,
    parameter int COLOUR_PLANES_ARE_IN_PARALLEL = 0,
    parameter int LOG2_NUMBER_OF_COLOUR_PLANES  = 2,
    parameter int DIM_WIDTH                     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 mode_change,
    input  logic                 hd_sdn,
    input  logic [DIM_WIDTH-1:0] h_active,
    input  logic [DIM_WIDTH-1:0] v_active,
    input  logic                 frame_start,
    input  logic                 active_req,
    input  logic                 vid_valid,
    input  logic                 vid_sop,
    input  logic                 vid_eop,
    output logic                 vid_ready,
    output logic                 data_take,
    output logic                 start_of_sample,
    output logic                 eol,
    output logic                 eof,
    output logic                 underflow,
    output logic                 misalign,
    input  logic                 clear_status,
    output logic [STATE_W-1:0]   state
`ifdef VID_SEQ_STATUS_COUNTERS_EN
    ,
    output logic [15:0]          underflow_count,
    output logic [15:0]          misalign_count
`endif
);

    localparam logic [DIM_WIDTH-1:0] ONE_D = DIM_WIDTH'(1);

    seq_state_e           r_state;
    logic [DIM_WIDTH-1:0] r_x, r_y, r_h, r_v;
    logic                 r_first, r_eol, r_eof, r_underflow, r_misalign;

    logic w_hold, w_active, w_req, w_take, w_strobe, w_sos, w_ready;
    logic w_x_last, w_y_last, w_frame_end;
    logic w_sop_err, w_first_err, w_eop_early, w_eop_missing;
    logic w_uf_evt, w_ma_evt;

    // mode_change and a dropped enable both park the sequencer in IDLE.
    assign w_hold   = mode_change | ~enable;
    assign w_active = (r_state == ACTIVE) & ~w_hold;
    assign w_req    = w_active & active_req & vid_valid;

    // A sop arriving mid-frame is left in the FIFO so RESYNC can lock on it.
    assign w_sop_err = w_req & vid_sop & ~r_first;
    assign w_take    = w_req & ~w_sop_err;

    vid_plane_phase_counter #(
        .NUMBER_OF_COLOUR_PLANES       (NUMBER_OF_COLOUR_PLANES),
        .COLOUR_PLANES_ARE_IN_PARALLEL (COLOUR_PLANES_ARE_IN_PARALLEL),
        .LOG2_NUMBER_OF_COLOUR_PLANES  (LOG2_NUMBER_OF_COLOUR_PLANES)
    ) u_phase (
        .clk               (clk),
        .rst               (rst),
        .i_clr             (w_hold | (r_state != ACTIVE)),
        .i_advance         (w_take),
        .i_hd_sdn          (hd_sdn),
        .o_start_of_sample (w_sos),
        .o_sample_strobe   (w_strobe)
    );

    assign w_x_last    = (r_x == (r_h - ONE_D));
    assign w_y_last    = (r_y == (r_v - ONE_D));
    assign w_frame_end = w_strobe & w_x_last & w_y_last;

    assign w_first_err   = w_req & r_first & ~vid_sop;
    assign w_eop_early   = w_take & vid_eop & ~w_frame_end;
    assign w_eop_missing = w_frame_end & ~vid_eop;
    assign w_ma_evt      = w_sop_err | w_first_err | w_eop_early | w_eop_missing;
    assign w_uf_evt      = w_active & active_req & ~vid_valid;

    // Beat acceptance: discard non-sop beats while hunting, take beats when active.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            SYNC, RESYNC: w_ready = vid_valid & ~vid_sop;
            ACTIVE:       w_ready = w_take;
            default:      w_ready = 1'b0;
        endcase
        if (w_hold) begin
            w_ready = 1'b0;
        end else begin
            w_ready = w_ready;
        end
    end

    assign vid_ready       = w_ready;
    assign data_take       = w_take;
    assign start_of_sample = w_sos;
    assign eol             = r_eol;
    assign eof             = r_eof;
    assign underflow       = r_underflow;
    assign misalign        = r_misalign;
    assign state           = r_state;

    // Sequencer FSM with x/y position tracking and line/frame end pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_h     <= '0;
            r_v     <= '0;
            r_first <= 1'b0;
            r_eol   <= 1'b0;
            r_eof   <= 1'b0;
        end else if (w_hold) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_first <= 1'b0;
            r_eol   <= 1'b0;
            r_eof   <= 1'b0;
        end else begin
            r_eol <= 1'b0;
            r_eof <= 1'b0;
            case (r_state)
                IDLE: r_state <= SYNC;
                SYNC, RESYNC: begin
                    if (vid_valid && vid_sop) begin
                        r_state <= WAIT_FRAME;
                    end
                end
                WAIT_FRAME: begin
                    if (frame_start) begin
                        r_state <= ACTIVE;
                        r_h     <= h_active;
                        r_v     <= v_active;
                        r_first <= 1'b1;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                ACTIVE: begin
                    if (w_take) begin
                        r_first <= 1'b0;
                    end
                    if (w_uf_evt || w_ma_evt) begin
                        r_state <= RESYNC;
                        r_x     <= '0;
                        r_y     <= '0;
                    end else if (w_strobe) begin
                        if (w_x_last) begin
                            r_x   <= '0;
                            r_eol <= 1'b1;
                            if (w_y_last) begin
                                r_y     <= '0;
                                r_eof   <= 1'b1;
                                r_state <= SYNC;
                            end else begin
                                r_y <= r_y + ONE_D;
                            end
                        end else begin
                            r_x <= r_x + ONE_D;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Sticky error flags; a new error outranks a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underflow <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_underflow <= w_uf_evt | (r_underflow & ~clear_status);
            r_misalign  <= w_ma_evt | (r_misalign & ~clear_status);
        end
    end

`ifdef VID_SEQ_STATUS_COUNTERS_EN
    logic [15:0] r_uf_cnt, r_ma_cnt;

    // Saturating error-event counters; an event during a clear restarts at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_uf_cnt <= 16'd0;
            r_ma_cnt <= 16'd0;
        end else begin
            if (w_uf_evt) begin
                r_uf_cnt <= clear_status ? 16'd1 : sat_inc(r_uf_cnt);
            end else if (clear_status) begin
                r_uf_cnt <= 16'd0;
            end
            if (w_ma_evt) begin
                r_ma_cnt <= clear_status ? 16'd1 : sat_inc(r_ma_cnt);
            end else if (clear_status) begin
                r_ma_cnt <= 16'd0;
            end
        end
    end

    assign underflow_count = r_uf_cnt;
    assign misalign_count  = r_ma_cnt;
`endif

endmodule

// File: tb/tb_vid_line_sequencer.sv
// Directed self-checking bench for vid_line_sequencer (N=3 serial planes).
module tb_vid_line_sequencer;

    logic        clk = 1'b0;
    logic        rst, enable, mode_change, hd_sdn, clear_status;
    logic [15:0] h_active, v_active;
    logic        frame_start, active_req, vid_valid, vid_sop, vid_eop;
    logic        vid_ready, data_take, start_of_sample, eol, eof, underflow, misalign;
    logic [2:0]  state;
`ifdef VID_SEQ_STATUS_COUNTERS_EN
    logic [15:0] underflow_count, misalign_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic       s_ready, s_take, s_sos, s_eol, s_eof, s_uf, s_ma;
    logic [2:0] s_state;
    logic [3:0] exp_v, got_v;

    always #5 clk = ~clk;

    vid_line_sequencer #(
        .NUMBER_OF_COLOUR_PLANES       (3),
        .COLOUR_PLANES_ARE_IN_PARALLEL (0),
        .LOG2_NUMBER_OF_COLOUR_PLANES  (2),
        .DIM_WIDTH                     (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .mode_change     (mode_change),
        .hd_sdn          (hd_sdn),
        .h_active        (h_active),
        .v_active        (v_active),
        .frame_start     (frame_start),
        .active_req      (active_req),
        .vid_valid       (vid_valid),
        .vid_sop         (vid_sop),
        .vid_eop         (vid_eop),
        .vid_ready       (vid_ready),
        .data_take       (data_take),
        .start_of_sample (start_of_sample),
        .eol             (eol),
        .eof             (eof),
        .underflow       (underflow),
        .misalign        (misalign),
        .clear_status    (clear_status),
        .state           (state)
`ifdef VID_SEQ_STATUS_COUNTERS_EN
        ,
        .underflow_count (underflow_count),
        .misalign_count  (misalign_count)
`endif
    );

    // One clock cycle: drive at negedge, sample combinational outputs 1 ns later,
    // sample registered outputs 1 ns after the rising edge, return at next negedge.
    task automatic cyc(input logic v, input logic s, input logic e, input logic a, input logic f);
        vid_valid = v; vid_sop = s; vid_eop = e; active_req = a; frame_start = f;
        #1;
        s_ready = vid_ready; s_take = data_take; s_sos = start_of_sample;
        @(posedge clk);
        #1;
        s_eol = eol; s_eof = eof; s_state = state; s_uf = underflow; s_ma = misalign;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; vid_valid = 1'b1; active_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (state !== 3'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", state); end
        n_cmp++;
        got_v = {vid_ready, data_take, eol, eof};
        if (got_v !== 4'b0000) begin n_err++; $display("FAIL reset_outputs got=%b exp=0000", got_v); end
        n_cmp++;
        if ({underflow, misalign} !== 2'b00) begin n_err++; $display("FAIL reset_flags got=%b exp=00", {underflow, misalign}); end
        @(negedge clk);
        rst = 1'b0; vid_valid = 1'b0; active_req = 1'b0;
    endtask

    // 24-beat frame (h=4, v=2, 3 planes), lock already in ACTIVE.
    task automatic run_frame24(input string tag);
        for (int b = 1; b <= 24; b++) begin
            cyc(1'b1, b == 1, b == 24, 1'b1, 1'b0);
            exp_v[3] = 1'b1;
            exp_v[2] = ((b - 1) % 3 == 0);
            exp_v[1] = (b == 12) || (b == 24);
            exp_v[0] = (b == 24);
            got_v = {s_take, s_sos, s_eol, s_eof};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL %s beat %0d take/sos/eol/eof got=%b exp=%b", tag, b, got_v, exp_v);
            end
        end
        n_cmp++;
        if (s_state !== 3'd1) begin n_err++; $display("FAIL %s end_state got=%0d exp=1", tag, s_state); end
    endtask

    task automatic lock_to_frame(input string tag);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({s_ready, s_state} !== {1'b0, 3'd2}) begin n_err++; $display("FAIL %s sop_hold ready/state got=%b/%0d exp=0/2", tag, s_ready, s_state); end
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if ({s_ready, s_state} !== {1'b0, 3'd3}) begin n_err++; $display("FAIL %s frame_start ready/state got=%b/%0d exp=0/3", tag, s_ready, s_state); end
    endtask

    task automatic test_full_frame();
        enable = 1'b1; hd_sdn = 1'b0; h_active = 16'd4; v_active = 16'd2;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (s_state !== 3'd1) begin n_err++; $display("FAIL full idle_to_sync got=%0d exp=1", s_state); end
        lock_to_frame("full");
        run_frame24("full");
        n_cmp++;
        if ({s_uf, s_ma} !== 2'b00) begin n_err++; $display("FAIL full flags got=%b exp=00", {s_uf, s_ma}); end
    endtask

    task automatic test_sync_discard();
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if ({s_ready, s_take, s_state} !== {1'b1, 1'b0, 3'd1}) begin
                n_err++; $display("FAIL discard beat %0d ready/take/state got=%b%b/%0d exp=10/1", i, s_ready, s_take, s_state);
            end
        end
        lock_to_frame("discard");
        run_frame24("discard");
    endtask

    task automatic test_underflow();
        lock_to_frame("uf");
        for (int b = 1; b <= 6; b++) cyc(1'b1, b == 1, 1'b0, 1'b1, 1'b0);
        clear_status = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        clear_status = 1'b0;
        n_cmp++;
        if ({s_ready, s_take, s_uf, s_state} !== {1'b0, 1'b0, 1'b1, 3'd4}) begin
            n_err++; $display("FAIL uf_event ready/take/uf/state got=%b%b%b/%0d exp=001/4", s_ready, s_take, s_uf, s_state);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({s_ready, s_state} !== {1'b1, 3'd4}) begin n_err++; $display("FAIL uf_resync_discard got=%b/%0d exp=1/4", s_ready, s_state); end
        lock_to_frame("uf_relock");
        run_frame24("uf_relock");
        n_cmp++;
        if ({s_uf, s_ma} !== 2'b10) begin n_err++; $display("FAIL uf_sticky got=%b exp=10", {s_uf, s_ma}); end
        clear_status = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        clear_status = 1'b0;
        n_cmp++;
        if (s_uf !== 1'b0) begin n_err++; $display("FAIL uf_clear got=%b exp=0", s_uf); end
    endtask

    task automatic test_misalign();
        lock_to_frame("ma");
        for (int b = 1; b <= 9; b++) cyc(1'b1, b == 1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({s_ready, s_take, s_ma, s_state} !== {1'b0, 1'b0, 1'b1, 3'd4}) begin
            n_err++; $display("FAIL ma_event ready/take/ma/state got=%b%b%b/%0d exp=001/4", s_ready, s_take, s_ma, s_state);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({s_ready, s_state, s_uf} !== {1'b0, 3'd2, 1'b0}) begin
            n_err++; $display("FAIL ma_relock ready/state/uf got=%b/%0d/%b exp=0/2/0", s_ready, s_state, s_uf);
        end
    endtask

    task automatic test_mode_change();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int b = 1; b <= 7; b++) cyc(1'b1, b == 1, 1'b0, 1'b1, 1'b0);
        mode_change = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mode_change = 1'b0;
        n_cmp++;
        if ({s_state, s_ma} !== {3'd0, 1'b1}) begin n_err++; $display("FAIL mode_change state/ma got=%0d/%b exp=0/1", s_state, s_ma); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        lock_to_frame("mc");
        run_frame24("mc");
        clear_status = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        clear_status = 1'b0;
        n_cmp++;
        if (s_ma !== 1'b0) begin n_err++; $display("FAIL ma_clear got=%b exp=0", s_ma); end
    endtask

    task automatic test_back_to_back_hd();
        hd_sdn = 1'b1; h_active = 16'd3; v_active = 16'd1;
        for (int f = 0; f < 2; f++) begin
            lock_to_frame("hd");
            for (int b = 1; b <= 3; b++) begin
                cyc(1'b1, b == 1, b == 3, 1'b1, 1'b0);
                exp_v = {1'b1, 1'b1, b == 3, b == 3};
                got_v = {s_take, s_sos, s_eol, s_eof};
                n_cmp++;
                if (got_v !== exp_v) begin
                    n_err++; $display("FAIL hd frame %0d beat %0d take/sos/eol/eof got=%b exp=%b", f, b, got_v, exp_v);
                end
            end
            n_cmp++;
            if ({s_state, s_uf, s_ma} !== {3'd1, 1'b0, 1'b0}) begin
                n_err++; $display("FAIL hd frame %0d end state/flags got=%0d/%b%b exp=1/00", f, s_state, s_uf, s_ma);
            end
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mode_change = 1'b0; hd_sdn = 1'b0; clear_status = 1'b0;
        h_active = 16'd4; v_active = 16'd2;
        frame_start = 1'b0; active_req = 1'b0; vid_valid = 1'b0; vid_sop = 1'b0; vid_eop = 1'b0;
        test_reset();
        test_full_frame();
        test_sync_discard();
        test_underflow();
        test_misalign();
        test_mode_change();
        test_back_to_back_hd();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vid_line_sequencer.md
Name: vid_line_sequencer

Overview:
Controller that paces an Avalon-ST video pixel stream into the clocked-video output path. It locks the input stream to frame starts from the output timing generator and issues ready/accept strobes on active-picture cycles. It tracks colour-plane sample phase and x/y position, detects underflow and misalignment, and re-synchronises. It sits between the input FIFO and the output mux/encoder.

Parameters:
NUMBER_OF_COLOUR_PLANES, 3, colour planes per pixel (1..4).
COLOUR_PLANES_ARE_IN_PARALLEL, 0, 1 = all planes in one beat (one beat = one sample).
LOG2_NUMBER_OF_COLOUR_PLANES, 2, width of the plane-phase counter (min 1).
DIM_WIDTH, 16, width of the h_active / v_active fields.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  sequencer run enable
mode_change  in  1  synchronous clear pulse: new mode loaded
hd_sdn  in  1  1 = one beat per sample (HD); 0 = planes serialised
h_active  in  DIM_WIDTH  active samples per line (>=1)
v_active  in  DIM_WIDTH  active lines per frame (>=1)
frame_start  in  1  timing generator: first active cycle of the frame is next
active_req  in  1  timing generator: this cycle is an active-picture beat
vid_valid  in  1  FIFO beat valid
vid_sop  in  1  FIFO beat is the first beat of a frame
vid_eop  in  1  FIFO beat is the last beat of a frame
vid_ready  out  1  beat accepted this cycle (combinational)
data_take  out  1  active beat delivered to output this cycle
start_of_sample  out  1  current accepted beat is plane 0
eol  out  1  registered pulse after the last beat of a line
eof  out  1  registered pulse after the last beat of a frame
underflow  out  1  sticky: active_req with no valid beat
misalign  out  1  sticky: sop/eop at an unexpected position
clear_status  in  1  clears the sticky flags
state  out  3  current FSM state (debug)

Behaviour:
- Reset: state=IDLE; x, y and plane phase = 0; eol, eof, underflow and misalign = 0; vid_ready and data_take = 0.
- Priority each cycle: rst > mode_change > !enable > FSM. mode_change or !enable forces IDLE and clears x, y and phase. Sticky flags are kept.
- States:
  - IDLE -> SYNC when enable.
  - SYNC: vid_ready = vid_valid & !vid_sop, which discards beats until a sop. On vid_valid & vid_sop, do not consume; go to WAIT_FRAME.
  - WAIT_FRAME: vid_ready = 0. On frame_start, go to ACTIVE.
  - ACTIVE: vid_ready = data_take = active_req & vid_valid. active_req & !vid_valid sets underflow and goes to RESYNC.
  - RESYNC: vid_ready = vid_valid & !vid_sop. On sop, go to WAIT_FRAME, which aligns to the next frame_start.
- Plane phase (serial mode, hd_sdn=0 and NUMBER_OF_COLOUR_PLANES>1): counts accepted beats 0..N-1 and wraps to 0.
  - start_of_sample = (phase==0).
  - The sample strobe fires on the beat where phase==N-1.
  - If hd_sdn=1, NUMBER_OF_COLOUR_PLANES=1 or COLOUR_PLANES_ARE_IN_PARALLEL=1: every beat is a sample and start_of_sample=1.
- Position:
  - On a sample strobe, x increments.
  - At x==h_active-1: x wraps to 0, eol pulses next cycle, and y increments.
  - At y==v_active-1 with x wrapping: eof pulses next cycle, y=0, and the FSM goes to SYNC.
- Misalignment:
  - The first accepted beat in ACTIVE must carry sop.
  - The final beat of the frame must carry eop.
  - sop accepted mid-frame, or eop before the final beat: set misalign and go to RESYNC. The offending beat is not consumed when it is a sop.
- Simultaneous clear_status and a new error: the set wins.
- Widths: x and y are DIM_WIDTH. Compares are unsigned. h_active and v_active are sampled when leaving WAIT_FRAME and held until eof.

Optional Feature:
VID_SEQ_STATUS_COUNTERS_EN:
- Defined: adds outputs underflow_count[15:0] and misalign_count[15:0]. They saturate at 0xFFFF, increment on each error event, and clear on clear_status or rst.
- Undefined: these ports and registers are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package vid_seq_pkg holds:
  - state enum IDLE=0, SYNC=1, WAIT_FRAME=2, ACTIVE=3, RESYNC=4;
  - the state width constant 3;
  - the saturation limit constant.
- One sub-module, vid_plane_phase_counter: the plane-phase counter with its sample strobe and start_of_sample logic, cleared synchronously on mode_change.

Test Plan:
- N=3, hd_sdn=0, h_active=4, v_active=2, continuous valid frame with sop/eop, active_req held 1 after frame_start -> 24 data_take beats; eol after beats 12 and 24; eof after beat 24; no flags set.
- Two non-sop beats ahead of the sop in SYNC -> both consumed with vid_ready=1, data_take=0; the sop beat is delivered on the first active_req after frame_start.
- vid_valid dropped for 1 cycle at beat 7 while active_req=1 -> underflow=1, state=RESYNC; lock is regained on the next sop plus frame_start.
- sop injected at beat 10 of 24 -> misalign=1, sop not consumed, state goes to WAIT_FRAME.
- mode_change pulsed mid-line at x=2 -> next cycle state=IDLE, x=y=0, phase=0; the sticky flags are unchanged.
- hd_sdn=1, h_active=3, v_active=1 -> start_of_sample=1 on every beat; eof after beat 3.
